// File: rtl/dmem_arbiter.sv
// Round-robin two-requester sequencer in front of the single-port dmem; DMEM_ARB_FIXED_PRIO_EN selects fixed r0-first priority.
// Latency: grant cycle N, memory access N+1, rvalid pulse N+2; one access per two cycles.
// Backpressure: requests are held until gnt; no grant is issued while an access is in flight.
module dmem_arbiter #(
    parameter int DW = 32,
    parameter int AW = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_req,
    input  logic          r0_we,
    input  logic [AW-1:0] r0_addr,
    input  logic [DW-1:0] r0_wdata,
    output logic          r0_gnt,
    output logic          r0_rvalid,
    output logic [DW-1:0] r0_rdata,
    input  logic          r1_req,
    input  logic          r1_we,
    input  logic [AW-1:0] r1_addr,
    input  logic [DW-1:0] r1_wdata,
    output logic          r1_gnt,
    output logic          r1_rvalid,
    output logic [DW-1:0] r1_rdata,
    output logic [31:0]   mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata_q;
    logic          we_q;
    logic          id_q;
    logic          last_id;
    logic          accept;
    logic          win1;
    logic          grant;

    // With last_id pinned to 1 the same select degenerates to r0-first priority.
`ifdef DMEM_ARB_FIXED_PRIO_EN
    assign last_id = 1'b1;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_id <= 1'b1;
        end else if (grant) begin
            last_id <= win1;
        end
    end
`endif

    assign accept = (state != ACCESS);
    assign win1   = r1_req & (~r0_req | ~last_id);
    assign r0_gnt = accept & r0_req & ~win1;
    assign r1_gnt = accept & win1;
    assign grant  = r0_gnt | r1_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            id_q    <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE, RESP: begin
                    if (grant) begin
                        state   <= ACCESS;
                        addr_q  <= win1 ? r1_addr  : r0_addr;
                        wdata_q <= win1 ? r1_wdata : r0_wdata;
                        we_q    <= win1 ? r1_we    : r0_we;
                        id_q    <= win1;
                    end else begin
                        state <= IDLE;
                    end
                end
                ACCESS: begin
                    rdata_q <= we_q ? '0 : mem_rdata;
                    state   <= RESP;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // mem_we decodes straight from state so an async reset drops it immediately.
    assign mem_addr  = {{(32-AW){1'b0}}, addr_q};
    assign mem_wdata = wdata_q;
    assign mem_we    = (state == ACCESS) & we_q;

    assign r0_rvalid = (state == RESP) & ~id_q;
    assign r1_rvalid = (state == RESP) & id_q;
    assign r0_rdata  = r0_rvalid ? rdata_q : '0;
    assign r1_rdata  = r1_rvalid ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural dmem attached.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0_req = 1'b0, r0_we = 1'b0;
    logic [19:0] r0_addr = '0;
    logic [31:0] r0_wdata = '0;
    logic        r0_gnt, r0_rvalid;
    logic [31:0] r0_rdata;
    logic        r1_req = 1'b0, r1_we = 1'b0;
    logic [19:0] r1_addr = '0;
    logic [31:0] r1_wdata = '0;
    logic        r1_gnt, r1_rvalid;
    logic [31:0] r1_rdata;
    logic [31:0] mem_addr;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int failures = 0;

    logic [31:0] mem [0:255] = '{default: 32'h0};

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr < 32'd256) ? mem[mem_addr[7:0]] : 32'h0;
    always @(posedge clk) if (mem_we) mem[mem_addr[7:0]] <= mem_wdata;

    dmem_arbiter #(.DW(32), .AW(20)) dut (
        .clk(clk), .rst(rst),
        .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
        .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_rdata(r0_rdata),
        .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
        .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_rdata(r1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic apply_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic access(input logic id, input logic we, input logic [19:0] a, input logic [31:0] d);
        @(negedge clk);
        if (id) begin
            r1_req = 1'b1; r1_we = we; r1_addr = a; r1_wdata = d;
        end else begin
            r0_req = 1'b1; r0_we = we; r0_addr = a; r0_wdata = d;
        end
        @(negedge clk);
        r0_req = 1'b0; r1_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (mem_we !== 1'b0 || r0_rvalid !== 1'b0 || r1_rvalid !== 1'b0)
            begin failures++; $display("FAIL reset_during: mem_we=%b rv0=%b rv1=%b, required 0", mem_we, r0_rvalid, r1_rvalid); end
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if ({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we} !== 5'b0 || r0_rdata !== 32'h0 ||
                r1_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0)
                begin failures++; $display("FAIL reset_idle[%0d]: gnt=%b%b rv=%b%b we=%b rd0=%h rd1=%h addr=%h wd=%h, required all 0",
                    i, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, mem_we, r0_rdata, r1_rdata, mem_addr, mem_wdata); end
        end
    endtask

    task automatic test_write_read();
        @(negedge clk);
        r0_req = 1'b1; r0_we = 1'b1; r0_addr = 20'h10; r0_wdata = 32'hDEADBEEF; #1;
        checks++;
        if (r0_gnt !== 1'b1 || r1_gnt !== 1'b0 || mem_we !== 1'b0)
            begin failures++; $display("FAIL wr_gnt: gnt0=%b gnt1=%b we=%b, required 1 0 0", r0_gnt, r1_gnt, mem_we); end
        @(negedge clk);
        r0_req = 1'b0; r0_we = 1'b0; #1;
        checks++;
        if (mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF || r0_gnt !== 1'b0)
            begin failures++; $display("FAIL wr_access: we=%b addr=%h wd=%h gnt0=%b, required 1 00000010 deadbeef 0", mem_we, mem_addr, mem_wdata, r0_gnt); end
        @(negedge clk);
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 20'h10; #1;
        checks++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== 32'h0 || mem_we !== 1'b0 || r0_gnt !== 1'b1)
            begin failures++; $display("FAIL wr_resp: rv0=%b rd0=%h we=%b gnt0=%b, required 1 0 0 1", r0_rvalid, r0_rdata, mem_we, r0_gnt); end
        @(negedge clk);
        r0_req = 1'b0; #1;
        checks++;
        if (mem_we !== 1'b0 || r0_rvalid !== 1'b0 || mem_addr !== 32'h10)
            begin failures++; $display("FAIL rd_access: we=%b rv0=%b addr=%h, required 0 0 00000010", mem_we, r0_rvalid, mem_addr); end
        @(negedge clk); #1;
        checks++;
        if (r0_rvalid !== 1'b1 || r0_rdata !== 32'hDEADBEEF || r1_rvalid !== 1'b0 || r1_rdata !== 32'h0)
            begin failures++; $display("FAIL rd_resp: rv0=%b rd0=%h rv1=%b rd1=%h, required 1 deadbeef 0 0", r0_rvalid, r0_rdata, r1_rvalid, r1_rdata); end
        @(negedge clk); #1;
        checks++;
        if (r0_rvalid !== 1'b0 || r0_rdata !== 32'h0)
            begin failures++; $display("FAIL rd_done: rv0=%b rd0=%h, required 0 0", r0_rvalid, r0_rdata); end
    endtask

    task automatic test_round_robin();
        logic [31:0] word [0:1];
        logic exp_g0, exp_g1, exp_v0, exp_v1;
        logic [31:0] exp_d0, exp_d1;
        int w;
        word[0] = 32'hA1; word[1] = 32'hB2;
        access(1'b1, 1'b1, 20'h1, 32'hA1);
        access(1'b1, 1'b1, 20'h2, 32'hB2);
        apply_reset();
        for (int c = 0; c <= 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                r0_req = 1'b1; r0_we = 1'b0; r0_addr = 20'h1;
                r1_req = 1'b1; r1_we = 1'b0; r1_addr = 20'h2;
            end
            if (c == 8) begin r0_req = 1'b0; r1_req = 1'b0; end
            #1;
`ifdef DMEM_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = (c / 2) % 2;
`endif
            exp_g0 = (c % 2 == 0) && (c < 8) && (w == 0);
            exp_g1 = (c % 2 == 0) && (c < 8) && (w == 1);
`ifdef DMEM_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = ((c - 2) / 2) % 2;
`endif
            exp_v0 = (c % 2 == 0) && (c >= 2) && (w == 0);
            exp_v1 = (c % 2 == 0) && (c >= 2) && (w == 1);
            exp_d0 = exp_v0 ? word[0] : 32'h0;
            exp_d1 = exp_v1 ? word[1] : 32'h0;
            checks++;
            if (r0_gnt !== exp_g0 || r1_gnt !== exp_g1 || r0_rvalid !== exp_v0 || r1_rvalid !== exp_v1 ||
                r0_rdata !== exp_d0 || r1_rdata !== exp_d1)
                begin failures++; $display("FAIL rr_cycle[%0d]: gnt=%b%b rv=%b%b rd0=%h rd1=%h, required gnt=%b%b rv=%b%b rd0=%h rd1=%h",
                    c, r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_rdata, r1_rdata,
                    exp_g0, exp_g1, exp_v0, exp_v1, exp_d0, exp_d1); end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        r1_req = 1'b1; r1_we = 1'b1; r1_addr = 20'h20; r1_wdata = 32'h55; #1;
        checks++;
        if (r1_gnt !== 1'b1 || r0_gnt !== 1'b0)
            begin failures++; $display("FAIL rst_gnt: gnt0=%b gnt1=%b, required 0 1", r0_gnt, r1_gnt); end
        @(negedge clk);
        r1_req = 1'b0; #1;
        checks++;
        if (mem_we !== 1'b1)
            begin failures++; $display("FAIL rst_access: we=%b, required 1", mem_we); end
        rst = 1'b1; #1;
        checks++;
        if (mem_we !== 1'b0)
            begin failures++; $display("FAIL rst_we_drop: we=%b, required 0", mem_we); end
        @(negedge clk); #1;
        checks++;
        if (mem[8'h20] !== 32'h0 || r1_rvalid !== 1'b0)
            begin failures++; $display("FAIL rst_no_commit: mem20=%h rv1=%b, required 0 0", mem[8'h20], r1_rvalid); end
        rst = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (r1_rvalid !== 1'b0 || mem_addr !== 32'h0 || mem[8'h20] !== 32'h0)
            begin failures++; $display("FAIL rst_after: rv1=%b addr=%h mem20=%h, required 0 0 0", r1_rvalid, mem_addr, mem[8'h20]); end
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 20'h20; #1;
        checks++;
        if (r1_gnt !== 1'b1)
            begin failures++; $display("FAIL rst_rd_gnt: gnt1=%b, required 1", r1_gnt); end
        @(negedge clk);
        r1_req = 1'b0;
        @(negedge clk); #1;
        checks++;
        if (r1_rvalid !== 1'b1 || r1_rdata !== 32'h0 || r0_rvalid !== 1'b0)
            begin failures++; $display("FAIL rst_rd_resp: rv1=%b rd1=%h rv0=%b, required 1 0 0", r1_rvalid, r1_rdata, r0_rvalid); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        r0_req = 1'b1; r0_we = 1'b0; r0_addr = 20'h1; #1;
        checks++;
        if (r0_gnt !== 1'b1)
            begin failures++; $display("FAIL b2b_gnt0: gnt0=%b, required 1", r0_gnt); end
        @(negedge clk);
        r0_req = 1'b0; #1;
        checks++;
        if (r0_gnt !== 1'b0 || r1_gnt !== 1'b0 || r0_rvalid !== 1'b0)
            begin failures++; $display("FAIL b2b_access: gnt=%b%b rv0=%b, required 00 0", r0_gnt, r1_gnt, r0_rvalid); end
        @(negedge clk);
        r1_req = 1'b1; r1_we = 1'b0; r1_addr = 20'h2; #1;
        checks++;
        if (r0_rvalid !== 1'b1 || r1_gnt !== 1'b1 || r0_rdata !== 32'hA1 || r0_gnt !== 1'b0 || r1_rdata !== 32'h0)
            begin failures++; $display("FAIL b2b_overlap: rv0=%b gnt1=%b rd0=%h gnt0=%b rd1=%h, required 1 1 000000a1 0 0",
                r0_rvalid, r1_gnt, r0_rdata, r0_gnt, r1_rdata); end
        @(negedge clk);
        r1_req = 1'b0; #1;
        checks++;
        if (mem_addr !== 32'h2 || r0_rvalid !== 1'b0 || mem_we !== 1'b0)
            begin failures++; $display("FAIL b2b_access1: addr=%h rv0=%b we=%b, required 00000002 0 0", mem_addr, r0_rvalid, mem_we); end
        @(negedge clk); #1;
        checks++;
        if (r1_rvalid !== 1'b1 || r1_rdata !== 32'hB2 || r0_rvalid !== 1'b0)
            begin failures++; $display("FAIL b2b_resp1: rv1=%b rd1=%h rv0=%b, required 1 000000b2 0", r1_rvalid, r1_rdata, r0_rvalid); end
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
